load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 143 ++++++++++++++
 tb/tb_load_store_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit bridging single CPU accesses onto a word-wide synchronous data memory.
// Byte stores use a read-modify-write sequence; misaligned word accesses fault.
module load_store_unit #(
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        byteEn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  output logic [31:0] memA,
  output logic [31:0] memWD,
  output logic        memOE,
  output logic        memWE,
  input  logic [31:0] memRD
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StRmwRd,
    StRmwWr,
    StWrite,
    StResp,
    StFault
  } state_t;

  state_t      state_q;
  logic        ready_q;
  logic        done_q;
  logic        fault_q;
  logic [31:0] rdata_q;
  logic        mem_oe_q;
  logic        mem_we_q;
  logic [31:0] mem_a_q;
  logic [31:0] mem_wd_q;
  logic [1:0]  lane_q;
  logic        byte_q;
  logic [7:0]  bdata_q;

  logic [7:0]  rd_lane;
  logic [31:0] rd_merged;
  logic        misaligned;

  // Lane extraction and byte merge both work on memRD directly, since the memory
  // returns data combinationally in the same cycle memOE is asserted.
  always_comb begin
    rd_lane = memRD[{lane_q, 3'b000} +: 8];
    rd_merged = memRD;
    rd_merged[{lane_q, 3'b000} +: 8] = bdata_q;
    misaligned = (ALIGN_CHECK != 0) && !byteEn && (addr[1:0] != 2'b00);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= 32'h0;
      mem_oe_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_a_q  <= 32'h0;
      mem_wd_q <= 32'h0;
      lane_q   <= 2'b00;
      byte_q   <= 1'b0;
      bdata_q  <= 8'h0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            ready_q <= 1'b0;
            mem_a_q <= {addr[31:2], 2'b00};
            lane_q  <= addr[1:0];
            byte_q  <= byteEn;
            bdata_q <= wdata[7:0];
            if (misaligned) begin
              state_q <= StFault;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else if (!we) begin
              state_q  <= StRead;
              mem_oe_q <= 1'b1;
            end else if (byteEn) begin
              state_q  <= StRmwRd;
              mem_oe_q <= 1'b1;
            end else begin
              state_q  <= StWrite;
              mem_we_q <= 1'b1;
              mem_wd_q <= wdata;
            end
          end
        end
        StRead: begin
          mem_oe_q <= 1'b0;
          rdata_q  <= byte_q ? {24'h0, rd_lane} : memRD;
          state_q  <= StResp;
          done_q   <= 1'b1;
        end
        StRmwRd: begin
          mem_oe_q <= 1'b0;
          mem_we_q <= 1'b1;
          mem_wd_q <= rd_merged;
          state_q  <= StRmwWr;
        end
        StRmwWr, StWrite: begin
          mem_we_q <= 1'b0;
          state_q  <= StResp;
          done_q   <= 1'b1;
        end
        StResp, StFault: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: begin
          state_q  <= StIdle;
          ready_q  <= 1'b1;
          mem_oe_q <= 1'b0;
          mem_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign fault = fault_q;
  assign rdata = rdata_q;
  assign memA  = mem_a_q;
  assign memWD = mem_wd_q;
  assign memOE = mem_oe_q;
  // Gated by reset so a reset landing on a write cycle never commits the store.
  assign memWE = mem_we_q & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        req;
  logic        we;
  logic        byteEn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        fault;
  logic [31:0] memA;
  logic [31:0] memWD;
  logic        memOE;
  logic        memWE;
  logic [31:0] memRD;

  logic [31:0] mem [16];
  int errors = 0;
  int checks = 0;
  logic done_prev = 1'b0;

  load_store_unit #(.ALIGN_CHECK(1)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .we    (we),
    .byteEn(byteEn),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .done  (done),
    .rdata (rdata),
    .fault (fault),
    .memA  (memA),
    .memWD (memWD),
    .memOE (memOE),
    .memWE (memWE),
    .memRD (memRD)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign memRD = mem[memA[5:2]];

  always @(posedge clock) begin
    if (memWE) mem[memA[5:2]] <= memWD;
  end

  // Global protocol checks sampled away from the active edge.
  always @(negedge clock) begin
    checks++;
    assert (!(memOE && memWE)) else begin
      errors++;
      $error("FAIL oe_we_overlap observed=%b expected=0", memOE && memWE);
    end
    checks++;
    assert (!(done_prev && done)) else begin
      errors++;
      $error("FAIL done_twice observed=%b expected=0", done);
    end
    done_prev = done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1;
    we = w;
    byteEn = b;
    addr = a;
    wdata = d;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h11223344;
    reset = 1'b1;
    req = 1'b0;
    we = 1'b0;
    byteEn = 1'b0;
    addr = 32'h0;
    wdata = 32'h0;
    tick();
    tick();
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_fault", fault, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_oe", memOE, 0);
    chk("rst_we", memWE, 0);
    chk("rst_memA", memA, 0);
    chk("rst_memWD", memWD, 0);
    reset = 1'b0;
    tick();

    // Word store 0xDEADBEEF to 0x8
    issue(1, 0, 32'h8, 32'hDEADBEEF);
    tick();
    req = 1'b0;
    chk("sw_we", memWE, 1);
    chk("sw_oe", memOE, 0);
    chk("sw_memA", memA, 32'h8);
    chk("sw_memWD", memWD, 32'hDEADBEEF);
    chk("sw_ready", ready, 0);
    chk("sw_done_early", done, 0);
    tick();
    chk("sw_done", done, 1);
    chk("sw_fault", fault, 0);
    chk("sw_we_off", memWE, 0);
    chk("sw_mem", mem[2], 32'hDEADBEEF);
    tick();
    chk("sw_idle", ready, 1);

    // Word load from 0x8
    issue(0, 0, 32'h8, 32'h0);
    tick();
    req = 1'b0;
    chk("lw_oe", memOE, 1);
    chk("lw_we", memWE, 0);
    chk("lw_done_early", done, 0);
    tick();
    chk("lw_done", done, 1);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    tick();

    // Byte store 0xAB to 0x6 over 0x11223344
    issue(1, 1, 32'h6, 32'hFFFFFFAB);
    tick();
    req = 1'b0;
    chk("sb_rd_oe", memOE, 1);
    chk("sb_rd_memA", memA, 32'h4);
    tick();
    chk("sb_wr_we", memWE, 1);
    chk("sb_wr_oe", memOE, 0);
    chk("sb_wr_memWD", memWD, 32'h11AB3344);
    chk("sb_wr_done", done, 0);
    tick();
    chk("sb_done", done, 1);
    chk("sb_mem", mem[1], 32'h11AB3344);
    tick();

    // Byte loads from lanes 2 and 3
    issue(0, 1, 32'h6, 32'h0);
    tick();
    req = 1'b0;
    tick();
    chk("lb6_done", done, 1);
    chk("lb6_rdata", rdata, 32'h000000AB);
    tick();
    issue(0, 1, 32'h7, 32'h0);
    tick();
    req = 1'b0;
    tick();
    chk("lb7_rdata", rdata, 32'h00000011);
    tick();

    // Misaligned word load and store
    issue(0, 0, 32'h2, 32'h0);
    tick();
    req = 1'b0;
    chk("mis_done", done, 1);
    chk("mis_fault", fault, 1);
    chk("mis_oe", memOE, 0);
    chk("mis_we", memWE, 0);
    chk("mis_rdata", rdata, 32'h00000011);
    chk("mis_ready", ready, 0);
    tick();
    chk("mis_idle", ready, 1);
    chk("mis_done_off", done, 0);
    chk("mis_fault_off", fault, 0);
    issue(1, 0, 32'hA, 32'h12345678);
    tick();
    req = 1'b0;
    chk("mis_st_fault", fault, 1);
    chk("mis_st_we", memWE, 0);
    tick();
    chk("mis_st_mem", mem[2], 32'hDEADBEEF);

    // req held high: address change while busy is ignored, next IDLE accepts
    issue(0, 0, 32'h8, 32'h0);
    tick();
    addr = 32'h4;
    chk("hs_busy", ready, 0);
    tick();
    chk("hs_first_rdata", rdata, 32'hDEADBEEF);
    tick();
    chk("hs_idle", ready, 1);
    tick();
    chk("hs_second_memA", memA, 32'h4);
    chk("hs_second_oe", memOE, 1);
    req = 1'b0;
    tick();
    chk("hs_second_rdata", rdata, 32'h11AB3344);
    tick();

    // Reset during RMW_RD aborts the byte store
    issue(1, 1, 32'h4, 32'h55);
    tick();
    req = 1'b0;
    chk("ab_rd_oe", memOE, 1);
    reset = 1'b1;
    tick();
    chk("ab_ready", ready, 1);
    chk("ab_done", done, 0);
    chk("ab_we", memWE, 0);
    reset = 1'b0;
    tick();
    tick();
    chk("ab_done_later", done, 0);
    chk("ab_mem", mem[1], 32'h11AB3344);

    // Reset during RMW_WR: write enable must drop with reset
    issue(1, 1, 32'h5, 32'h66);
    tick();
    req = 1'b0;
    tick();
    chk("abw_we_before", memWE, 1);
    reset = 1'b1;
    #1;
    chk("abw_we_gated", memWE, 0);
    tick();
    reset = 1'b0;
    chk("abw_mem", mem[1], 32'h11AB3344);
    chk("abw_ready", ready, 1);
    tick();
    chk("abw_done", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
